seg7_capture: RTL

Reverse path of the hex-to-segment decoder: passively monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus digit selects) and reconstructs the hex value shown on each digit. It sits beside the display driver in lab designs and in self-checking benches, where it turns what the board would show into a 32-bit value plus per-digit status. Debouncing requires a stable pattern before capture, and a frame strobe marks a complete scan.

---
 rtl/seg7_capture.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// Passive monitor for a multiplexed active-low 7-segment bus: debounces each
// digit's pattern and rebuilds the displayed hex value with per-digit status.
module seg7_capture #(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [6:0]                             seg,
  input  logic [NDIG-1:0]                        an,
  output logic [4*NDIG-1:0]                      value,
  output logic [NDIG-1:0]                        digit_valid,
  output logic [NDIG-1:0]                        blank,
  output logic                                   upd,
  output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] upd_idx,
  output logic                                   err,
  output logic                                   frame_done
);

  localparam int         IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] CNT_MAX = 8'(STABLE - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Returns {legal, nibble}; blank and unknown patterns report legal = 0.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]        s_seg;
  logic [NDIG-1:0]   s_an;
  logic [7:0]        cnt;
  logic              committed;
  logic [NDIG-1:0]   seen;

  logic [NDIG-1:0]   sel_p0;
  logic              one_zero_p0;
  logic [4:0]        dec_p0;
  logic              legal_p0;
  logic              blank_hit_p0;
  logic              vld_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [4*NDIG-1:0] value_nx;
  logic [NDIG-1:0]   dv_nx;
  logic [NDIG-1:0]   blank_nx;
  logic [NDIG-1:0]   seen_nx;
  logic              same_p0;

  // Stage p0: decode the held sample and decide whether it commits this edge
  always_comb begin
    sel_p0       = ~s_an;
    one_zero_p0  = (sel_p0 != '0) && ((sel_p0 & (sel_p0 - NDIG'(1))) == '0);
    dec_p0       = glyph_decode(s_seg);
    legal_p0     = dec_p0[4];
    blank_hit_p0 = (s_seg == SEG_OFF);
    vld_p0       = (cnt == CNT_MAX) && !committed && one_zero_p0;
    same_p0      = (seg == s_seg) && (an == s_an);
    idx_p0       = '0;
    value_nx     = value;
    dv_nx        = digit_valid;
    blank_nx     = blank;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_p0[i]) begin
        idx_p0 = IDX_W'(i);
        if (legal_p0) value_nx[4*i +: 4] = dec_p0[3:0];
        dv_nx[i]    = legal_p0;
        blank_nx[i] = blank_hit_p0;
      end
    end
    seen_nx = seen | sel_p0;
  end

  // Sample register and stability tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg     <= SEG_OFF;
      s_an      <= '1;
      cnt       <= '0;
      committed <= 1'b0;
    end else begin
      s_seg <= seg;
      s_an  <= an;
      if (!same_p0) begin
        cnt       <= '0;
        committed <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        if (vld_p0) committed <= 1'b1;
      end
    end
  end

  // Stage p1: committed digit state and one-cycle event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      blank       <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      upd        <= vld_p0;
      err        <= vld_p0 && !legal_p0 && !blank_hit_p0;
      frame_done <= vld_p0 && (&seen_nx);
      if (vld_p0) begin
        upd_idx     <= idx_p0;
        value       <= value_nx;
        digit_valid <= dv_nx;
        blank       <= blank_nx;
        seen        <= (&seen_nx) ? '0 : seen_nx;
      end
    end
  end

endmodule
